// File: rtl/fault_detection_monitor_mc.sv
// fault_detection_monitor_mc: per-link parity fault monitor that classifies each NoC input link as OK, SUSPECT or FAULTY.
// Transient errors decay away while SUSPECT; FAULTY is sticky until the channel is cleared.
module fault_detection_monitor_mc #(
    parameter int FLIT_WIDTH    = 32,
    parameter int NUM_CH        = 5,
    parameter int PARITY_GRAN   = 8,
    parameter int ROUTER_STAGES = 2,
    parameter int CNT_WIDTH     = 8,
    parameter int THRESHOLD     = 4,
    parameter int DECAY_WINDOW  = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CH*FLIT_WIDTH-1:0]    in_flit,
    input  logic [NUM_CH-1:0]               in_valid,
    input  logic [NUM_CH*(FLIT_WIDTH/PARITY_GRAN)-1:0] in_parity,
    input  logic [NUM_CH-1:0]               clr_ch,
    output logic [NUM_CH-1:0]               out_error,
    output logic [NUM_CH*2-1:0]             out_state,
    output logic [NUM_CH*CNT_WIDTH-1:0]     err_cnt,
    output logic                            any_fault
);
    localparam int NGRP = FLIT_WIDTH / PARITY_GRAN;
    localparam int DW = DECAY_WINDOW > 0 ? $clog2(DECAY_WINDOW + 1) : 1;
    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_SUS = 2'b01;
    localparam logic [1:0] ST_FLT = 2'b10;

    if (FLIT_WIDTH % PARITY_GRAN != 0) begin : g_bad_gran
        $fatal(1, "FLIT_WIDTH must be a multiple of PARITY_GRAN");
    end
    if (THRESHOLD < 1 || THRESHOLD > 2 ** CNT_WIDTH - 1) begin : g_bad_thr
        $fatal(1, "THRESHOLD must lie in 1..2**CNT_WIDTH-1");
    end
    if (ROUTER_STAGES != 1 && ROUTER_STAGES != 2) begin : g_bad_stages
        $fatal(1, "ROUTER_STAGES must be 1 or 2");
    end

    // Outside FAULTY the state is a pure function of the error count.
    function automatic logic [1:0] classify(input logic [CNT_WIDTH-1:0] cnt);
        return cnt >= CNT_WIDTH'(THRESHOLD) ? ST_FLT : (cnt == '0 ? ST_OK : ST_SUS);
    endfunction

    logic [NUM_CH-1:0] flt;
    logic              any_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [FLIT_WIDTH-1:0] flit;
        logic [NGRP-1:0]       exp_par;
        logic                  mis;
        logic                  dec_hit;
        logic [1:0]            st_q, st_d;
        logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_upd;
        logic [DW-1:0]         dec_q, dec_d;
        logic                  last_q, last_d;

        assign flit = in_flit[c*FLIT_WIDTH +: FLIT_WIDTH];
        for (genvar g = 0; g < NGRP; g++) begin : g_grp
            assign exp_par[g] = ~^flit[g*PARITY_GRAN +: PARITY_GRAN];
        end
        assign mis = in_valid[c] & |(exp_par ^ in_parity[c*NGRP +: NGRP]);
        assign dec_hit = DECAY_WINDOW != 0 && in_valid[c] && !mis && st_q == ST_SUS
                         && dec_q == DW'(DECAY_WINDOW - 1);

        always_ff @(posedge clk) begin
            if (rst) begin
                st_q   <= ST_OK;
                cnt_q  <= '0;
                dec_q  <= '0;
                last_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                dec_q  <= dec_d;
                last_q <= last_d;
            end
        end

        // A clear lands on the state for the count that includes this cycle's mismatch.
        always_comb begin
            cnt_upd = mis ? (&cnt_q ? cnt_q : cnt_q + 1'b1) : (dec_hit ? cnt_q - 1'b1 : cnt_q);
            cnt_d   = clr_ch[c] ? CNT_WIDTH'(mis) : cnt_upd;
            st_d    = (st_q == ST_FLT && !clr_ch[c]) ? ST_FLT : classify(cnt_d);
            last_d  = (clr_ch[c] || in_valid[c]) ? mis : last_q;
            dec_d   = (clr_ch[c] || mis || dec_hit || st_d != st_q || st_q != ST_SUS || DECAY_WINDOW == 0)
                      ? '0 : (in_valid[c] ? dec_q + 1'b1 : dec_q);
        end

        assign out_error[c]                    = last_q | (st_q == ST_FLT) | (ROUTER_STAGES == 1 && !rst && mis);
        assign out_state[c*2 +: 2]             = st_q;
        assign err_cnt[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
        assign flt[c]                          = st_q == ST_FLT;
    end

    always_ff @(posedge clk) begin
        any_q <= rst ? 1'b0 : |flt;
    end

    assign any_fault = any_q;
endmodule

// File: tb/tb_fault_detection_monitor_mc.sv
// tb_fault_detection_monitor_mc: three monitor configurations driven by shared flits, checked against a rule-level model.
// Instance a is the default build, b has a 4-bit counter, c reports same-cycle with 16-bit parity groups.
module tb_fault_detection_monitor_mc;
    localparam int NC = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [159:0] in_flit;
    logic [4:0]   in_valid, clr_ch;
    logic [19:0]  par_a;
    logic [9:0]   par_c;
    logic [4:0]   err_a, err_b, err_c;
    logic [9:0]   st_a, st_b, st_c;
    logic [39:0]  cnt_a, cnt_c;
    logic [19:0]  cnt_b;
    logic         any_a, any_b, any_c;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int m_cnt[3][NC], m_st[3][NC], m_dec[3][NC], m_last[3][NC], m_mis[3][NC], m_any[3];

    always #5 clk = ~clk;

    fault_detection_monitor_mc u_a (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_parity(par_a), .clr_ch(clr_ch),
        .out_error(err_a), .out_state(st_a), .err_cnt(cnt_a), .any_fault(any_a));

    fault_detection_monitor_mc #(.CNT_WIDTH(4)) u_b (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_parity(par_a), .clr_ch(clr_ch),
        .out_error(err_b), .out_state(st_b), .err_cnt(cnt_b), .any_fault(any_b));

    fault_detection_monitor_mc #(.ROUTER_STAGES(1), .PARITY_GRAN(16)) u_c (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_parity(par_c), .clr_ch(clr_ch),
        .out_error(err_c), .out_state(st_c), .err_cnt(cnt_c), .any_fault(any_c));

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Odd parity: a group plus its parity bit holds an odd number of ones.
    function automatic bit mis_of(int d, int c);
        int gran;
        logic [31:0] f;
        bit m;
        gran = (d == 2) ? 16 : 8;
        f = in_flit[c*32 +: 32];
        m = 0;
        for (int g = 0; g < 32 / gran; g++) begin
            int ones;
            bit p;
            ones = $countones((f >> (g * gran)) & ((32'h1 << gran) - 1));
            p = (d == 2) ? par_c[c*2+g] : par_a[c*4+g];
            if ((ones + int'(p)) % 2 == 0) m = 1;
        end
        return in_valid[c] && m;
    endfunction

    function automatic int classify(int cnt);
        return cnt >= 4 ? 2 : (cnt == 0 ? 0 : 1);
    endfunction

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            int cmax;
            int anyf;
            cmax = (d == 1) ? 15 : 255;
            anyf = 0;
            for (int c = 0; c < NC; c++) if (m_st[d][c] == 2) anyf = 1;
            m_any[d] = rst ? 0 : anyf;
            for (int c = 0; c < NC; c++) begin
                int mis;
                int old;
                mis = int'(mis_of(d, c));
                old = m_st[d][c];
                m_mis[d][c] = mis;
                if (rst) begin
                    m_cnt[d][c] = 0; m_st[d][c] = 0; m_dec[d][c] = 0; m_last[d][c] = 0;
                end else if (clr_ch[c]) begin
                    m_cnt[d][c] = mis; m_st[d][c] = classify(mis); m_dec[d][c] = 0; m_last[d][c] = mis;
                end else begin
                    if (in_valid[c]) m_last[d][c] = mis;
                    if (mis != 0) m_cnt[d][c] = (m_cnt[d][c] < cmax) ? m_cnt[d][c] + 1 : cmax;
                    else if (in_valid[c] && old == 1) begin
                        m_dec[d][c]++;
                        if (m_dec[d][c] == 64) begin
                            m_cnt[d][c]--;
                            m_dec[d][c] = 0;
                        end
                    end
                    if (old != 2) m_st[d][c] = classify(m_cnt[d][c]);
                    if (mis != 0 || m_st[d][c] != old) m_dec[d][c] = 0;
                end
            end
        end
    endtask

    task automatic check_all(string tag);
        logic [63:0] ee[3], es[3], ec[3];
        for (int d = 0; d < 3; d++) begin
            ee[d] = '0; es[d] = '0; ec[d] = '0;
            for (int c = 0; c < NC; c++) begin
                int w;
                w = (d == 1) ? 4 : 8;
                ee[d][c] = m_last[d][c] != 0 || m_st[d][c] == 2 || (d == 2 && !rst && m_mis[d][c] != 0);
                es[d][c*2 +: 2] = 2'(m_st[d][c]);
                ec[d] = ec[d] | (64'(m_cnt[d][c]) << (c * w));
            end
        end
        chk({tag, "/err_a"}, 64'(err_a), ee[0]);
        chk({tag, "/st_a"},  64'(st_a),  es[0]);
        chk({tag, "/cnt_a"}, 64'(cnt_a), ec[0]);
        chk({tag, "/any_a"}, 64'(any_a), 64'(m_any[0]));
        chk({tag, "/err_b"}, 64'(err_b), ee[1]);
        chk({tag, "/st_b"},  64'(st_b),  es[1]);
        chk({tag, "/cnt_b"}, 64'(cnt_b), ec[1]);
        chk({tag, "/any_b"}, 64'(any_b), 64'(m_any[1]));
        chk({tag, "/err_c"}, 64'(err_c), ee[2]);
        chk({tag, "/st_c"},  64'(st_c),  es[2]);
        chk({tag, "/cnt_c"}, 64'(cnt_c), ec[2]);
        chk({tag, "/any_c"}, 64'(any_c), 64'(m_any[2]));
    endtask

    task automatic set_in(logic [4:0] v, logic [4:0] bad, logic [4:0] clr, int b);
        for (int c = 0; c < NC; c++) begin
            logic [31:0] f;
            f = $urandom;
            for (int g = 0; g < 4; g++) par_a[c*4+g] = ($countones(f[g*8 +: 8]) % 2 == 0);
            for (int g = 0; g < 2; g++) par_c[c*2+g] = ($countones(f[g*16 +: 16]) % 2 == 0);
            if (bad[c]) f[b] = ~f[b];
            in_flit[c*32 +: 32] = f;
        end
        in_valid = v;
        clr_ch = clr;
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic send(logic [4:0] v, logic [4:0] bad, logic [4:0] clr, int b, string tag);
        set_in(v, bad, clr, b);
        step(tag);
    endtask

    function automatic logic [4:0] rand_mask(int n);
        logic [4:0] m;
        for (int c = 0; c < NC; c++) m[c] = ($urandom_range(0, n - 1) == 0);
        return m;
    endfunction

    initial begin
        rst = 1'b1;
        set_in('0, '0, '0, 0);
        step("reset");
        step("reset");
        chk("rst_cnt", 64'(cnt_a), 64'd0);
        chk("rst_err", 64'(err_c), 64'd0);
        chk("rst_any", 64'(any_a), 64'd0);
        rst = 1'b0;

        repeat (100) send('1, '0, '0, 0, "clean");
        chk("clean_state", 64'(st_a), 64'd0);
        chk("clean_cnt", 64'(cnt_a), 64'd0);
        chk("clean_err", 64'(err_a), 64'd0);

        send('1, 5'b00100, '0, 3, "trans");
        chk("trans_cnt", 64'(cnt_a[23:16]), 64'd1);
        chk("trans_state", 64'(st_a[5:4]), 64'd1);
        chk("trans_err", 64'(err_a[2]), 64'd1);
        send('1, '0, '0, 0, "decay");
        chk("trans_pulse_end", 64'(err_a[2]), 64'd0);
        repeat (62) send('1, '0, '0, 0, "decay");
        chk("decay63_state", 64'(st_a[5:4]), 64'd1);
        send('1, '0, '0, 0, "decay");
        chk("decay64_cnt", 64'(cnt_a[23:16]), 64'd0);
        chk("decay64_state", 64'(st_a[5:4]), 64'd0);

        for (int k = 0; k < 4; k++) begin
            send('1, 5'b00001, '0, 5, "thr");
            if (k < 3) repeat (10) send('1, '0, '0, 0, "thr");
        end
        chk("thr_state", 64'(st_a[1:0]), 64'd2);
        chk("thr_any_lag", 64'(any_a), 64'd0);
        send('1, '0, '0, 0, "thr");
        chk("thr_any", 64'(any_a), 64'd1);
        repeat (5) send('1, '0, '0, 0, "thr");
        chk("thr_sticky_err", 64'(err_a[0]), 64'd1);

        repeat (20) send('1, 5'b00010, '0, 7, "sat");
        chk("sat_cnt_b", 64'(cnt_b[7:4]), 64'd15);
        chk("sat_cnt_a", 64'(cnt_a[15:8]), 64'd20);

        send('1, 5'b00001, 5'b00001, 2, "clr");
        chk("clr_mis_cnt", 64'(cnt_a[7:0]), 64'd1);
        chk("clr_mis_state", 64'(st_a[1:0]), 64'd1);
        send('1, '0, 5'b00001, 0, "clr");
        chk("clr_cnt", 64'(cnt_a[7:0]), 64'd0);
        chk("clr_state", 64'(st_a[1:0]), 64'd0);
        chk("clr_err", 64'(err_a[0]), 64'd0);
        send('1, '0, 5'b00010, 0, "clr");

        set_in('1, 5'b10000, '0, 20);
        #1;
        chk("s1_same_cycle", 64'(err_c[4]), 64'd1);
        chk("s2_no_same_cycle", 64'(err_a[4]), 64'd0);
        step("s1");
        send('1, 5'b10000, '0, 21, "s1");
        send('1, 5'b10000, '0, 17, "s1");
        rst = 1'b1;
        send('1, '1, '0, 9, "midrst");
        chk("midrst_err_c", 64'(err_c), 64'd0);
        chk("midrst_st_c", 64'(st_c), 64'd0);
        chk("midrst_cnt_a", 64'(cnt_a), 64'd0);
        chk("midrst_any_a", 64'(any_a), 64'd0);
        rst = 1'b0;

        repeat (400) begin
            rst = ($urandom_range(0, 199) == 0);
            send(5'($urandom), rand_mask(6), rand_mask(40), $urandom_range(0, 31), "rand_hi");
        end
        rst = 1'b0;
        send('1, '0, '1, 0, "rand_clr");
        repeat (600) begin
            send(5'($urandom) | 5'($urandom), rand_mask(100), rand_mask(300), $urandom_range(0, 31), "rand_lo");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
